wsmac_pe: RTL and testbench
===========================

// Module: wsmac_pe
// PURPOSE
//  Weight-stationary systolic PE on a gated clock (en_clk from upstream ICG cell).
//  Forwards fmap/weight to neighbours with 1-cycle delay.
//  Holds a double-buffered weight, so a shadow load overlaps compute.
//  Accumulates ACC_LEN-configurable windows of fmap*weight products, signed or unsigned, saturating.
// PARAMETERS
//  I_F_BW  8   fmap width
//  W_BW    8   weight width
//  M_BW    16  product width (must equal I_F_BW+W_BW)
//  AK_BW   20  accumulator/output width (must be > M_BW)
//  CNT_BW  8   window-length counter width
// PORTS
//  en_clk        in  1       gated clock; all state holds while stopped
//  rst_n         in  1       async active-low reset
//  i_valid       in  1       i_fmap is a valid compute operand this cycle
//  i_fmap        in  I_F_BW  fmap from west neighbour
//  i_weight      in  W_BW    weight from north neighbour
//  i_w_load      in  1       write i_weight into the shadow bank
//  i_w_swap      in  1       shadow bank becomes active next cycle
//  i_signed      in  1       1: two's-complement operands/accum; 0: unsigned
//  i_acc_clr     in  1       sync clear of accumulator, counter, pipeline valids
//  i_acc_len     in  CNT_BW  products per output window; 0 treated as 1
//  o_fmap        out I_F_BW  registered i_fmap to east
//  o_weight      out W_BW    registered i_weight to south
//  o_valid       out 1       registered i_valid to east
//  o_acc_kernel  out AK_BW   completed window sum (held until next window completes)
//  o_acc_valid   out 1       1-cycle pulse: o_acc_kernel updated
//  o_ovf         out 1       sticky: saturation occurred; cleared by i_acc_clr/reset
// BEHAVIOUR
//  Reset: all outputs 0, both banks 0, active bank = 0, counter 0, state S_IDLE.
//  Pass-through: o_fmap/o_weight/o_valid <= inputs every cycle (independent of valid).
//  Weights: bank[~act] <= i_weight on i_w_load; act <= ~act on i_w_swap.
//   Load+swap same cycle: write goes to pre-swap shadow, so the new value is active next cycle.
//   Swap mid-window is legal; new weight applies to products launched the cycle after.
//  Pipe: S1 (i_valid) prod <= i_fmap*bank[act], sign- or zero-ext per i_signed sampled at S1.
//   S2 acc <= sat(acc + ext(prod)) to AK_BW.
//   Latency: last valid operand at cycle t -> o_acc_valid at t+2.
//  Saturation: signed clamps to [-2^(AK_BW-1), 2^(AK_BW-1)-1]; unsigned to [0, 2^AK_BW-1].
//   Any clamp sets o_ovf.
//  FSM: S_IDLE -> S_ACC on the first S2 product; window length latched from i_acc_len then.
//   S_ACC counts S2 products; on count == len:
//    o_acc_kernel <= sat(acc+prod), o_acc_valid = 1, acc <= 0, count <= 0, -> S_IDLE.
//   Back-to-back windows with no bubble are supported (next product starts a fresh sum).
//  len == 1: each valid product emits directly; o_acc_valid may be high every cycle.
//  i_acc_clr: highest priority; clears acc, count, S1/S2 valids, o_ovf, and returns to S_IDLE.
//   In-flight products are dropped. o_acc_kernel holds, o_acc_valid = 0.
//   Does not affect weight banks or pass-through registers.
//  i_acc_len changes mid-window are ignored until the next window starts.
//  Gating: en_clk stop freezes all state incl. in-flight pipe; resume continues exactly.
//  Async reset mid-window: everything to reset values, no pulse emitted.
// STRUCTURE
//  Shared pkg pe_pkg: state encodings S_IDLE/S_ACC, sat helper function (signed/unsigned, width param).
//  One sub-module: pe_wbank (2-entry weight double buffer, load/swap/active read).
//  MAC, counter and FSM stay inline; product computed combinationally then registered in S1.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all outputs 0 immediately; after release o_acc_valid stays 0 until a full window.
//  2 Unsigned, len=4, w=3, fmap 1,2,3,4 on consecutive cycles -> o_acc_kernel=30, single pulse 2 cycles after fmap 4.
//  3 Signed, len=2, w=-128, fmap -128,-128 -> 32768 (fits 20b); len=32, same operands -> clamp 524287, o_ovf=1.
//  4 Double buffer: active w=2, load 5 during window, swap on last operand -> sums use 2; next window uses 5; load+swap same cycle -> next product uses new value.
//  5 i_acc_clr one cycle after 2nd of 4 operands -> no pulse, o_ovf=0; next 4-operand window sums only new data.
//  6 Stop en_clk 5 cycles mid-window, then resume -> result and pulse identical to ungated run; o_fmap/o_weight delayed exactly 1 active edge.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary MAC PE: FSM encoding and a
// width-generic saturation helper.
package pe_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } pe_state_t;

  localparam int SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] val;
    logic             clamp;
  } sat_t;

  // Clamp a wide sum to w bits; sgn selects two's-complement or unsigned range.
  function automatic sat_t sat(input logic signed [SAT_W-1:0] sum,
                               input int unsigned w,
                               input logic sgn);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t r;
    if (sgn) begin
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
    end else begin
      hi = (64'sd1 <<< w) - 64'sd1;
      lo = '0;
    end
    r.val   = sum;
    r.clamp = 1'b0;
    if (sum > hi) begin
      r.val   = hi;
      r.clamp = 1'b1;
    end else if (sum < lo) begin
      r.val   = lo;
      r.clamp = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_wbank.sv
// Two-entry weight double buffer: loads land in the shadow entry, swap flips
// which entry drives the multiplier.
module pe_wbank #(
  parameter int W_BW = 8
) (
  input  logic            en_clk,
  input  logic            rst_n,
  input  logic            i_w_load,
  input  logic            i_w_swap,
  input  logic [W_BW-1:0] i_weight,
  output logic [W_BW-1:0] o_w_act
);

  logic            act_reg;
  logic [W_BW-1:0] bank_reg [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic IDX = 1'(gi);
      // Write targets the pre-swap shadow, so load+swap activates the new value.
      always_ff @(posedge en_clk or negedge rst_n) begin
        if (!rst_n) begin
          bank_reg[gi] <= '0;
        end else if (i_w_load && (act_reg != IDX)) begin
          bank_reg[gi] <= i_weight;
        end
      end
    end
  endgenerate

  always_ff @(posedge en_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_reg <= 1'b0;
    end else if (i_w_swap) begin
      act_reg <= ~act_reg;
    end
  end

  assign o_w_act = bank_reg[act_reg];

endmodule

// File: rtl/wsmac_pe.sv
// Weight-stationary systolic MAC PE: forwards operands east/south and
// accumulates configurable-length windows of saturating products.
module wsmac_pe
  import pe_pkg::*;
#(
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int M_BW   = 16,
  parameter int AK_BW  = 20,
  parameter int CNT_BW = 8
) (
  input  logic              en_clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [I_F_BW-1:0] i_fmap,
  input  logic [W_BW-1:0]   i_weight,
  input  logic              i_w_load,
  input  logic              i_w_swap,
  input  logic              i_signed,
  input  logic              i_acc_clr,
  input  logic [CNT_BW-1:0] i_acc_len,
  output logic [I_F_BW-1:0] o_fmap,
  output logic [W_BW-1:0]   o_weight,
  output logic              o_valid,
  output logic [AK_BW-1:0]  o_acc_kernel,
  output logic              o_acc_valid,
  output logic              o_ovf
);

  logic [W_BW-1:0] w_act;

  pe_wbank #(.W_BW(W_BW)) u_wbank (
    .en_clk   (en_clk),
    .rst_n    (rst_n),
    .i_w_load (i_w_load),
    .i_w_swap (i_w_swap),
    .i_weight (i_weight),
    .o_w_act  (w_act)
  );

  logic signed [M_BW-1:0] fmap_sx, w_sx, prod_s;
  logic        [M_BW-1:0] fmap_zx, w_zx, prod_u, prod_comb;

  assign fmap_sx   = M_BW'($signed(i_fmap));
  assign w_sx      = M_BW'($signed(w_act));
  assign fmap_zx   = M_BW'(i_fmap);
  assign w_zx      = M_BW'(w_act);
  assign prod_s    = fmap_sx * w_sx;
  assign prod_u    = fmap_zx * w_zx;
  assign prod_comb = i_signed ? prod_s : prod_u;

  logic              s1_valid_reg;
  logic              s1_signed_reg;
  logic [M_BW-1:0]   prod_reg;
  pe_state_t         state_reg;
  logic [CNT_BW-1:0] cnt_reg;
  logic [CNT_BW-1:0] len_reg;
  logic [AK_BW-1:0]  acc_reg;

  logic signed [SAT_W-1:0] acc_x, prod_x, sum_x;
  sat_t              sat_r;
  logic [AK_BW-1:0]  acc_sum;
  logic [CNT_BW-1:0] len_eff, win_len, cnt_next;
  logic              win_done;

  // The S1 signedness travels with the product so S2 extends and clamps consistently.
  always_comb begin
    acc_x    = s1_signed_reg ? SAT_W'($signed(acc_reg)) : SAT_W'(acc_reg);
    prod_x   = s1_signed_reg ? SAT_W'($signed(prod_reg)) : SAT_W'(prod_reg);
    sum_x    = acc_x + prod_x;
    sat_r    = sat(sum_x, AK_BW, s1_signed_reg);
    acc_sum  = AK_BW'(sat_r.val);
    len_eff  = (i_acc_len == '0) ? CNT_BW'(1) : i_acc_len;
    win_len  = (state_reg == S_IDLE) ? len_eff : len_reg;
    cnt_next = cnt_reg + CNT_BW'(1);
    win_done = (cnt_next == win_len);
  end

  always_ff @(posedge en_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fmap        <= '0;
      o_weight      <= '0;
      o_valid       <= 1'b0;
      o_acc_kernel  <= '0;
      o_acc_valid   <= 1'b0;
      o_ovf         <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_signed_reg <= 1'b0;
      prod_reg      <= '0;
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      len_reg       <= '0;
      acc_reg       <= '0;
    end else begin
      o_fmap      <= i_fmap;
      o_weight    <= i_weight;
      o_valid     <= i_valid;
      o_acc_valid <= 1'b0;
      if (i_acc_clr) begin
        s1_valid_reg <= 1'b0;
        acc_reg      <= '0;
        cnt_reg      <= '0;
        state_reg    <= S_IDLE;
        o_ovf        <= 1'b0;
      end else begin
        s1_valid_reg <= i_valid;
        if (i_valid) begin
          prod_reg      <= prod_comb;
          s1_signed_reg <= i_signed;
        end
        if (s1_valid_reg) begin
          if (sat_r.clamp) o_ovf <= 1'b1;
          if (state_reg == S_IDLE) len_reg <= len_eff;
          if (win_done) begin
            o_acc_kernel <= acc_sum;
            o_acc_valid  <= 1'b1;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            state_reg    <= S_IDLE;
          end else begin
            acc_reg   <= acc_sum;
            cnt_reg   <= cnt_next;
            state_reg <= S_ACC;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wsmac_pe.sv
// Directed self-checking bench for wsmac_pe, including clock-gating and reset cases.
module tb_wsmac_pe;

  logic        clk_free = 1'b0;
  logic        gate = 1'b1;
  logic        en_clk;
  logic        rst_n;
  logic        i_valid, i_w_load, i_w_swap, i_signed, i_acc_clr;
  logic [7:0]  i_fmap, i_weight, i_acc_len;
  logic [7:0]  o_fmap, o_weight;
  logic        o_valid, o_acc_valid, o_ovf;
  logic [19:0] o_acc_kernel;

  int n_vec = 0;
  int n_err = 0;
  int pulses;

  always #5 clk_free = ~clk_free;
  assign en_clk = clk_free & gate;

  wsmac_pe dut (
    .en_clk       (en_clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_fmap       (i_fmap),
    .i_weight     (i_weight),
    .i_w_load     (i_w_load),
    .i_w_swap     (i_w_swap),
    .i_signed     (i_signed),
    .i_acc_clr    (i_acc_clr),
    .i_acc_len    (i_acc_len),
    .o_fmap       (o_fmap),
    .o_weight     (o_weight),
    .o_valid      (o_valid),
    .o_acc_kernel (o_acc_kernel),
    .o_acc_valid  (o_acc_valid),
    .o_ovf        (o_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge en_clk);
    #1;
  endtask

  task automatic idle();
    tick();
    i_w_load  = 1'b0;
    i_w_swap  = 1'b0;
    i_acc_clr = 1'b0;
  endtask

  task automatic op(input logic [7:0] f);
    i_valid = 1'b1;
    i_fmap  = f;
    idle();
    i_valid = 1'b0;
  endtask

  task automatic set_w(input logic [7:0] w);
    i_weight = w;
    i_w_load = 1'b1;
    i_w_swap = 1'b1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_w_load = 1'b0; i_w_swap = 1'b0;
    i_signed = 1'b0; i_acc_clr = 1'b0; i_fmap = '0; i_weight = '0; i_acc_len = 8'd2;
    #1;
    chk("rst_kernel", 32'(o_acc_kernel), 0);
    chk("rst_acc_valid", 32'(o_acc_valid), 0);
    chk("rst_ovf", 32'(o_ovf), 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset mid-window: a len=2 pulse would otherwise appear one edge later
    set_w(8'd3);
    op(8'd5);
    op(8'd6);
    chk("pre_rst_fmap", 32'(o_fmap), 6);
    rst_n = 1'b0;
    #1;
    chk("rst_fmap", 32'(o_fmap), 0);
    chk("rst_weight", 32'(o_weight), 0);
    chk("rst_valid", 32'(o_valid), 0);
    idle();
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      idle();
      if (o_acc_valid) pulses++;
    end
    chk("rst_no_pulse", 32'(pulses), 0);
    chk("rst_kernel_held", 32'(o_acc_kernel), 0);

    // Unsigned window of four, weight 3
    set_w(8'd3);
    i_acc_len = 8'd4;
    op(8'd1); op(8'd2); op(8'd3);
    chk("u4_early", 32'(o_acc_valid), 0);
    op(8'd4);
    chk("u4_fmap_fwd", 32'(o_fmap), 4);
    chk("u4_lat1", 32'(o_acc_valid), 0);
    idle();
    chk("u4_pulse", 32'(o_acc_valid), 1);
    chk("u4_sum", 32'(o_acc_kernel), 30);
    idle();
    chk("u4_single", 32'(o_acc_valid), 0);
    chk("u4_hold", 32'(o_acc_kernel), 30);

    // Signed: fits, negative, then clamp
    i_signed = 1'b1;
    set_w(8'h80);
    i_acc_len = 8'd2;
    op(8'h80); op(8'h80);
    idle();
    chk("s2_pulse", 32'(o_acc_valid), 1);
    chk("s2_sum", 32'(o_acc_kernel), 32'h08000);
    chk("s2_ovf", 32'(o_ovf), 0);
    op(8'h7F); op(8'h7F);
    idle();
    chk("s2_neg", 32'(o_acc_kernel), 32'hF8100);
    i_acc_len = 8'd32;
    repeat (32) op(8'h80);
    idle();
    chk("s32_pulse", 32'(o_acc_valid), 1);
    chk("s32_clamp", 32'(o_acc_kernel), 32'h7FFFF);
    chk("s32_ovf", 32'(o_ovf), 1);
    idle();
    chk("ovf_sticky", 32'(o_ovf), 1);
    i_acc_clr = 1'b1;
    idle();
    chk("ovf_clr", 32'(o_ovf), 0);

    // Double buffer: shadow load mid-window, swap on last operand
    i_signed = 1'b0;
    set_w(8'd2);
    i_acc_len = 8'd3;
    op(8'd1);
    i_weight = 8'd5; i_w_load = 1'b1;
    op(8'd2);
    i_w_swap = 1'b1;
    op(8'd3);
    idle();
    chk("db_old_w", 32'(o_acc_kernel), 12);
    op(8'd1); op(8'd1); op(8'd1);
    idle();
    chk("db_new_w", 32'(o_acc_kernel), 15);
    i_weight = 8'd7; i_w_load = 1'b1; i_w_swap = 1'b1;
    op(8'd1); op(8'd1); op(8'd1);
    idle();
    chk("db_load_swap", 32'(o_acc_kernel), 19);

    // Clear mid-window drops accumulated and in-flight products
    i_acc_len = 8'd4;
    op(8'd1); op(8'd2);
    i_acc_clr = 1'b1;
    idle();
    pulses = 0;
    repeat (3) begin
      idle();
      if (o_acc_valid) pulses++;
    end
    chk("clr_no_pulse", 32'(pulses), 0);
    chk("clr_ovf", 32'(o_ovf), 0);
    chk("clr_kernel_held", 32'(o_acc_kernel), 19);
    op(8'd1); op(8'd1); op(8'd1); op(8'd1);
    idle();
    chk("clr_next_pulse", 32'(o_acc_valid), 1);
    chk("clr_next_sum", 32'(o_acc_kernel), 28);

    // len=0 behaves as len=1: back-to-back pulses
    i_acc_len = 8'd0;
    op(8'd3);
    chk("l1_first_lat", 32'(o_acc_valid), 0);
    op(8'd4);
    chk("l1_pulse_a", 32'(o_acc_valid), 1);
    chk("l1_sum_a", 32'(o_acc_kernel), 21);
    idle();
    chk("l1_pulse_b", 32'(o_acc_valid), 1);
    chk("l1_sum_b", 32'(o_acc_kernel), 28);
    idle();
    chk("l1_end", 32'(o_acc_valid), 0);

    // Clock stopped five cycles mid-window
    i_acc_len = 8'd4;
    i_weight = 8'h11;
    op(8'd1); op(8'd2);
    chk("gate_weight_pre", 32'(o_weight), 32'h11);
    i_valid = 1'b1; i_fmap = 8'd3; i_weight = 8'h22;
    gate = 1'b0;
    repeat (5) @(posedge clk_free);
    #1;
    chk("gate_fmap_frozen", 32'(o_fmap), 2);
    chk("gate_weight_frozen", 32'(o_weight), 32'h11);
    chk("gate_no_pulse", 32'(o_acc_valid), 0);
    @(negedge clk_free);
    gate = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("gate_fmap_resume", 32'(o_fmap), 3);
    chk("gate_weight_resume", 32'(o_weight), 32'h22);
    op(8'd4);
    idle();
    chk("gate_pulse", 32'(o_acc_valid), 1);
    chk("gate_sum", 32'(o_acc_kernel), 70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
